// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter serialising several APB requesters onto one APB master port.
// Request capture and response are registered; a bounded wait counter aborts hung accesses.
module apb_rr_arbiter #(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NB_REQ-1:0]                  req_psel_i,
  input  logic [NB_REQ-1:0]                  req_penable_i,
  input  logic [NB_REQ-1:0]                  req_pwrite_i,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   req_paddr_i,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   req_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]          req_prdata_o,
  output logic [NB_REQ-1:0]                  req_pready_o,
  output logic [NB_REQ-1:0]                  req_pslverr_o,
  output logic                               psel_o,
  output logic                               penable_o,
  output logic                               pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
  output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]          prdata_i,
  input  logic                               pready_i,
  input  logic                               pslverr_i,
  output logic [NB_REQ-1:0]                  grant_o,
  output logic                               timeout_o
);

  localparam int PW  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int PW1 = PW + 1;
  localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [PW-1:0]               r_rr_ptr;
  logic [PW-1:0]               r_owner;
  logic [NB_REQ-1:0]           r_grant;
  logic [APB_ADDR_WIDTH-1:0]   r_paddr;
  logic [APB_DATA_WIDTH-1:0]   r_pwdata;
  logic                        r_pwrite;
  logic [APB_DATA_WIDTH-1:0]   r_prdata;
  logic                        r_pslverr;
  logic                        r_timeout;
  logic [CW-1:0]               r_wait_cnt;

  logic                        w_any_pending;
  logic [PW-1:0]               w_win_idx;
  logic [PW1-1:0]              w_cand;
  logic                        w_timeout;
  logic                        w_psel;
  logic                        w_penable;
  logic [PW-1:0]               w_rr_next;
  logic                        w_unused;

  logic [APB_ADDR_WIDTH-1:0]   w_paddr_arr  [NB_REQ];
  logic [APB_DATA_WIDTH-1:0]   w_pwdata_arr [NB_REQ];

  // Only psel marks a pending request; penable carries no arbitration meaning.
  assign w_unused = ^req_penable_i;

  genvar gi;
  generate
    for (gi = 0; gi < NB_REQ; gi++) begin : g_req
      assign w_paddr_arr[gi]   = req_paddr_i[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
      assign w_pwdata_arr[gi]  = req_pwdata_i[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      assign req_pready_o[gi]  = (r_state == RESP) & r_grant[gi];
      assign req_pslverr_o[gi] = (r_state == RESP) & r_grant[gi] & r_pslverr;
    end
  endgenerate

  // First pending index at or after r_rr_ptr, wrapping modulo NB_REQ.
  always_comb begin
    w_any_pending = 1'b0;
    w_win_idx     = '0;
    w_cand        = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + PW1'(i);
      if (w_cand >= PW1'(NB_REQ)) begin
        w_cand = w_cand - PW1'(NB_REQ);
      end
      if (!w_any_pending && req_psel_i[w_cand[PW-1:0]]) begin
        w_any_pending = 1'b1;
        w_win_idx     = w_cand[PW-1:0];
      end
    end
  end

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == CW'(TIMEOUT_CYCLES)) && !pready_i;
  assign w_rr_next = (r_owner == PW'(NB_REQ - 1)) ? '0 : r_owner + PW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_psel       = 1'b0;
    w_penable    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_pending) w_state_next = SETUP;
      end
      SETUP: begin
        w_psel       = 1'b1;
        w_state_next = ACCESS;
      end
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (pready_i || w_timeout) w_state_next = RESP;
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_pwrite   <= 1'b0;
      r_prdata   <= '0;
      r_pslverr  <= 1'b0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_pending) begin
            r_grant  <= {{(NB_REQ-1){1'b0}}, 1'b1} << w_win_idx;
            r_owner  <= w_win_idx;
            r_paddr  <= w_paddr_arr[w_win_idx];
            r_pwdata <= w_pwdata_arr[w_win_idx];
            r_pwrite <= req_pwrite_i[w_win_idx];
          end
        end
        SETUP: begin
          r_wait_cnt <= '0;
        end
        ACCESS: begin
          // A real response in the timeout cycle takes priority over the abort.
          if (pready_i) begin
            r_prdata  <= prdata_i;
            r_pslverr <= pslverr_i;
          end else if (w_timeout) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b1;
            r_timeout <= 1'b1;
          end
          if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + CW'(1);
        end
        RESP: begin
          r_grant  <= '0;
          r_rr_ptr <= w_rr_next;
        end
        default: ;
      endcase
    end
  end

  assign psel_o       = w_psel;
  assign penable_o    = w_penable;
  assign pwrite_o     = r_pwrite;
  assign paddr_o      = r_paddr;
  assign pwdata_o     = r_pwdata;
  assign req_prdata_o = r_prdata;
  assign grant_o      = r_grant;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed self-checking bench for apb_rr_arbiter with two requesters and a short timeout.
module tb_apb_rr_arbiter;

  localparam int NB = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NB-1:0]     req_psel_i;
  logic [NB-1:0]     req_penable_i;
  logic [NB-1:0]     req_pwrite_i;
  logic [NB*AW-1:0]  req_paddr_i;
  logic [NB*DW-1:0]  req_pwdata_i;
  logic [DW-1:0]     req_prdata_o;
  logic [NB-1:0]     req_pready_o;
  logic [NB-1:0]     req_pslverr_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [AW-1:0]     paddr_o;
  logic [DW-1:0]     pwdata_o;
  logic [DW-1:0]     prdata_i;
  logic              pready_i;
  logic              pslverr_i;
  logic [NB-1:0]     grant_o;
  logic              timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  apb_rr_arbiter #(
    .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_psel_i(req_psel_i), .req_penable_i(req_penable_i), .req_pwrite_i(req_pwrite_i),
    .req_paddr_i(req_paddr_i), .req_pwdata_i(req_pwdata_i),
    .req_prdata_o(req_prdata_o), .req_pready_o(req_pready_o), .req_pslverr_o(req_pslverr_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int idx, input logic sel, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_psel_i[idx]            = sel;
    req_penable_i[idx]         = 1'b0;
    req_pwrite_i[idx]          = wr;
    req_paddr_i[idx*AW +: AW]  = addr;
    req_pwdata_i[idx*DW +: DW] = wdata;
  endtask

  initial begin
    rst_i = 1'b1;
    req_psel_i = '0; req_penable_i = '0; req_pwrite_i = '0;
    req_paddr_i = '0; req_pwdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    repeat (3) tick();

    chk("reset_psel", psel_o, 0);
    chk("reset_grant", grant_o, 0);
    chk("reset_pready", req_pready_o, 0);
    chk("reset_timeout", timeout_o, 0);
    rst_i = 1'b0;
    tick();

    // Single read from requester 0
    set_req(0, 1'b1, 1'b0, 32'h1A10_0000, 32'h0);
    pready_i = 1'b1; prdata_i = 32'hDEAD_BEEF; pslverr_i = 1'b0;
    tick();
    chk("rd_setup_psel", psel_o, 1);
    chk("rd_setup_penable", penable_o, 0);
    chk("rd_setup_grant", grant_o, 2'b01);
    chk("rd_setup_paddr", paddr_o, 32'h1A10_0000);
    req_penable_i[0] = 1'b1;
    tick();
    chk("rd_access_psel", psel_o, 1);
    chk("rd_access_penable", penable_o, 1);
    chk("rd_access_pready", req_pready_o, 0);
    tick();
    chk("rd_resp_pready", req_pready_o, 2'b01);
    chk("rd_resp_prdata", req_prdata_o, 32'hDEAD_BEEF);
    chk("rd_resp_pslverr", req_pslverr_o, 0);
    chk("rd_resp_grant", grant_o, 2'b01);
    chk("rd_resp_psel", psel_o, 0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rd_idle_pready", req_pready_o, 0);
    chk("rd_idle_grant", grant_o, 0);

    // Contention after reset: both requesters continuously pending
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h1A10_1000, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h1A10_3000, 32'h0);
    pready_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      automatic int own = t % 2;
      automatic logic [1:0] g = 2'b01 << own;
      automatic logic [31:0] a = (own == 0) ? 32'h1A10_1000 : 32'h1A10_3000;
      prdata_i = 32'hC0DE_0000 + t;
      tick();
      chk($sformatf("rr%0d_grant", t), grant_o, g);
      chk($sformatf("rr%0d_paddr", t), paddr_o, a);
      tick();
      tick();
      chk($sformatf("rr%0d_pready", t), req_pready_o, g);
      chk($sformatf("rr%0d_prdata", t), req_prdata_o, 32'hC0DE_0000 + t);
      if (t == 3) begin
        req_psel_i = '0;
      end
      tick();
      chk($sformatf("rr%0d_idle_grant", t), grant_o, 0);
    end

    // Write from requester 1 with three downstream wait states and an error response
    set_req(1, 1'b1, 1'b1, 32'h1A10_2000, 32'h1234_5678);
    pready_i = 1'b0; pslverr_i = 1'b1;
    tick();
    chk("wr_setup_grant", grant_o, 2'b10);
    chk("wr_setup_pwrite", pwrite_o, 1);
    chk("wr_setup_pwdata", pwdata_o, 32'h1234_5678);
    chk("wr_setup_paddr", paddr_o, 32'h1A10_2000);
    req_pwdata_i[DW +: DW] = 32'hFFFF_FFFF;
    for (int w = 0; w < 4; w++) begin
      tick();
      chk($sformatf("wr_acc%0d_penable", w), penable_o, 1);
      chk($sformatf("wr_acc%0d_pwdata", w), pwdata_o, 32'h1234_5678);
      chk($sformatf("wr_acc%0d_pready", w), req_pready_o, 0);
      if (w == 3) pready_i = 1'b1;
    end
    tick();
    chk("wr_resp_pready", req_pready_o, 2'b10);
    chk("wr_resp_pslverr", req_pslverr_o, 2'b10);
    chk("wr_resp_psel", psel_o, 0);
    req_psel_i = '0; pslverr_i = 1'b0;
    tick();

    // Timeout on requester 0 while requester 1 waits
    set_req(0, 1'b1, 1'b0, 32'h1A10_4000, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h1A10_5000, 32'h0);
    pready_i = 1'b0; prdata_i = 32'hBAD0_BAD0;
    tick();
    chk("to_setup_grant", grant_o, 2'b01);
    for (int a = 1; a <= TO + 1; a++) begin
      tick();
      chk($sformatf("to_acc%0d_psel", a), psel_o, 1);
      chk($sformatf("to_acc%0d_timeout", a), timeout_o, 0);
    end
    tick();
    chk("to_resp_timeout", timeout_o, 1);
    chk("to_resp_pready", req_pready_o, 2'b01);
    chk("to_resp_pslverr", req_pslverr_o, 2'b01);
    chk("to_resp_prdata", req_prdata_o, 0);
    chk("to_resp_psel", psel_o, 0);
    req_psel_i[0] = 1'b0;
    tick();
    chk("to_idle_timeout", timeout_o, 0);
    tick();
    chk("to_next_grant", grant_o, 2'b10);
    chk("to_next_paddr", paddr_o, 32'h1A10_5000);
    pready_i = 1'b1; prdata_i = 32'h600D_600D;
    tick();
    tick();
    chk("to_next_pready", req_pready_o, 2'b10);
    chk("to_next_prdata", req_prdata_o, 32'h600D_600D);
    chk("to_next_pslverr", req_pslverr_o, 0);
    chk("to_next_timeout", timeout_o, 0);
    req_psel_i[1] = 1'b0;
    tick();

    // Reset mid-ACCESS with the pointer advanced past requester 0
    set_req(0, 1'b1, 1'b0, 32'h1A10_6000, 32'h0);
    pready_i = 1'b1;
    tick();
    tick();
    tick();
    chk("rm_first_pready", req_pready_o, 2'b01);
    tick();
    pready_i = 1'b0;
    tick();
    chk("rm_second_grant", grant_o, 2'b01);
    tick();
    chk("rm_access_penable", penable_o, 1);
    rst_i = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h1A10_7000, 32'h0);
    tick();
    chk("rm_psel", psel_o, 0);
    chk("rm_penable", penable_o, 0);
    chk("rm_pwrite", pwrite_o, 0);
    chk("rm_paddr", paddr_o, 0);
    chk("rm_pwdata", pwdata_o, 0);
    chk("rm_prdata", req_prdata_o, 0);
    chk("rm_pready", req_pready_o, 0);
    chk("rm_pslverr", req_pslverr_o, 0);
    chk("rm_grant", grant_o, 0);
    chk("rm_timeout", timeout_o, 0);
    rst_i = 1'b0;
    tick();
    chk("rm_restart_grant", grant_o, 2'b01);
    chk("rm_restart_paddr", paddr_o, 32'h1A10_6000);
    chk("rm_restart_pready", req_pready_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
